// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial LSB-first subtractor, diff = a - b, one bit per clock
// Optional signed-overflow flag built only when SUB_SIGNED_OVF_EN is defined.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bOut,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]       state;
  logic [CW-1:0]    count;
  logic             borrow;
  logic [WIDTH-1:0] sh_a;
  logic [WIDTH-1:0] sh_b;
  logic [WIDTH-2:0] sh_d;

  logic             x_bit;
  logic             y_bit;
  logic             d_bit;
  logic             br_next;
  logic             accept;
  logic             last_bit;
  logic [WIDTH-1:0] d_vec;

  // One full-subtractor cell, reused for every bit position
  assign x_bit    = sh_a[0];
  assign y_bit    = sh_b[0];
  assign d_bit    = x_bit ^ y_bit ^ borrow;
  assign br_next  = (~x_bit & y_bit) | (~(x_bit ^ y_bit) & borrow);
  assign d_vec    = {d_bit, sh_d};

  assign accept   = start && ((state == ST_IDLE) || (state == ST_DONE));
  assign last_bit = (count == CW'(WIDTH - 1));

  assign busy     = (state == ST_RUN);
  assign done     = (state == ST_DONE);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state  <= ST_IDLE;
      count  <= '0;
      borrow <= 1'b0;
      sh_a   <= '0;
      sh_b   <= '0;
      sh_d   <= '0;
      diff   <= '0;
      bOut   <= 1'b0;
    end else if (accept) begin
      state  <= ST_RUN;
      sh_a   <= a;
      sh_b   <= b;
      borrow <= 1'b0;
      count  <= '0;
    end else if (state == ST_RUN) begin
      sh_a   <= sh_a >> 1;
      sh_b   <= sh_b >> 1;
      sh_d   <= d_vec[WIDTH-1:1];
      borrow <= br_next;
      count  <= count + 1'b1;
      if (last_bit) begin
        state <= ST_DONE;
        diff  <= d_vec;
        bOut  <= br_next;
      end
    end else begin
      state <= ST_IDLE;
    end
  end

`ifdef SUB_SIGNED_OVF_EN
  logic a_msb;
  logic b_msb;

  // Signed overflow: operands differ in sign and the result sign differs from the minuend
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      a_msb    <= 1'b0;
      b_msb    <= 1'b0;
      overflow <= 1'b0;
    end else if (accept) begin
      a_msb <= a[WIDTH-1];
      b_msb <= b[WIDTH-1];
    end else if ((state == ST_RUN) && last_bit) begin
      overflow <= (a_msb != b_msb) && (d_bit != a_msb);
    end
  end
`else
  assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - self-checking bench for serial_subtractor (WIDTH=8)
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       resetN;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       busy;
  logic       done;
  logic [7:0] diff;
  logic       bOut;
  logic       overflow;

  int checks = 0;
  int errors = 0;

  serial_subtractor #(.WIDTH(8)) dut (
    .clk(clk), .resetN(resetN), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .diff(diff), .bOut(bOut), .overflow(overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] ref_diff(input logic [7:0] av, input logic [7:0] bv);
    int r;
    r = (int'(av) - int'(bv) + 256) % 256;
    return r[7:0];
  endfunction

  function automatic logic ref_borrow(input logic [7:0] av, input logic [7:0] bv);
    return int'(av) < int'(bv);
  endfunction

  function automatic logic ref_ovf(input logic [7:0] av, input logic [7:0] bv);
`ifdef SUB_SIGNED_OVF_EN
    int sa, sb, r;
    sa = int'(byte'(av));
    sb = int'(byte'(bv));
    r  = sa - sb;
    return (r > 127) || (r < -128);
`else
    return 1'b0;
`endif
  endfunction

  // Launch one operation; lat counts falling edges from start acceptance to the done sample
  task automatic do_op(input logic [7:0] av, input logic [7:0] bv, output int lat, output int bc);
    @(negedge clk);
    a = av; b = bv; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    bc = 0;
    while (!done && lat < 40) begin
      if (busy) bc++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic check_op(input string name, input logic [7:0] av, input logic [7:0] bv);
    int lat, bc;
    do_op(av, bv, lat, bc);
    checks++;
    if (lat !== 9 || done !== 1'b1) begin
      errors++;
      $display("FAIL %s latency got %0d done=%b want 9 done=1", name, lat, done);
    end
    checks++;
    if (diff !== ref_diff(av, bv) || bOut !== ref_borrow(av, bv) || overflow !== ref_ovf(av, bv)) begin
      errors++;
      $display("FAIL %s a=%h b=%h got diff=%h bOut=%b ovf=%b want diff=%h bOut=%b ovf=%b",
               name, av, bv, diff, bOut, overflow, ref_diff(av, bv), ref_borrow(av, bv), ref_ovf(av, bv));
    end
  endtask

  task automatic test_reset();
    resetN = 1'b0; start = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || diff !== 8'h00 || bOut !== 1'b0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got busy=%b done=%b diff=%h bOut=%b ovf=%b want all 0",
               busy, done, diff, bOut, overflow);
    end
    resetN = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int lat, bc;
    do_op(8'h05, 8'h03, lat, bc);
    checks++;
    if (lat !== 9 || bc !== 8) begin
      errors++;
      $display("FAIL basic_timing got lat=%0d busy_cycles=%0d want lat=9 busy_cycles=8", lat, bc);
    end
    checks++;
    if (diff !== 8'h02 || bOut !== 1'b0) begin
      errors++;
      $display("FAIL basic_result got diff=%h bOut=%b want 02 0", diff, bOut);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL done_single_pulse got done=%b want 0", done);
    end
  endtask

  task automatic test_directed();
    check_op("sub_03_05", 8'h03, 8'h05);
    check_op("wrap_00_ff", 8'h00, 8'hFF);
    check_op("ovf_80_01", 8'h80, 8'h01);
    check_op("equal_5a", 8'h5A, 8'h5A);
    check_op("ovf_7f_ff", 8'h7F, 8'hFF);
  endtask

  task automatic test_restart_ignored();
    int pulses = 0;
    logic [7:0] seen = 8'h00;
    @(negedge clk);
    a = 8'h10; b = 8'h01; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    a = 8'h77; b = 8'h33; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (done) begin pulses++; seen = diff; end
      @(negedge clk);
    end
    checks++;
    if (pulses !== 1 || seen !== 8'h0F) begin
      errors++;
      $display("FAIL restart_ignored got pulses=%0d diff=%h want 1 0f", pulses, seen);
    end
  endtask

  task automatic test_async_reset();
    int pulses = 0;
    @(negedge clk);
    a = 8'h40; b = 8'h01; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 resetN = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || diff !== 8'h00 || bOut !== 1'b0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL async_reset got busy=%b done=%b diff=%h bOut=%b ovf=%b want all 0",
               busy, done, diff, bOut, overflow);
    end
    @(negedge clk);
    resetN = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (done) pulses++;
      @(negedge clk);
    end
    checks++;
    if (pulses !== 0) begin
      errors++;
      $display("FAIL no_done_after_reset got pulses=%0d want 0", pulses);
    end
    check_op("after_reset_22_11", 8'h22, 8'h11);
  endtask

  task automatic test_back_to_back();
    int last = -1;
    int pulses = 0;
    @(negedge clk);
    a = 8'h09; b = 8'h04; start = 1'b1;
    for (int t = 0; t < 60; t++) begin
      @(negedge clk);
      if (done) begin
        if (last >= 0) begin
          checks++;
          if (t - last !== 9) begin
            errors++;
            $display("FAIL b2b_period got %0d want 9", t - last);
          end
        end
        last = t;
        pulses++;
      end
      if (last >= 0) begin
        checks++;
        if (diff !== 8'h05) begin
          errors++;
          $display("FAIL b2b_diff_stable t=%0d got %h want 05", t, diff);
        end
      end
    end
    checks++;
    if (pulses < 6) begin
      errors++;
      $display("FAIL b2b_pulse_count got %0d want >=6", pulses);
    end
    start = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  task automatic test_random();
    logic [7:0] ra, rb;
    for (int i = 0; i < 24; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      check_op("random", ra, rb);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_directed();
    test_restart_ignored();
    test_async_reset();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
